demux1_32: RTL and testbench



---
 rtl/demux1_32_pkg.sv | 21 ++
 rtl/demux1_32_if.sv | 25 ++
 rtl/demux1_32_decoder.sv | 23 ++
 rtl/demux1_32.sv | 41 ++++
 tb/tb_demux1_32.sv | 117 +++++++++++
 5 files changed

// File: rtl/demux1_32_pkg.sv
// Shared sizing constants and the one-hot decode helper for the demux1_32 slice.
package demux1_32_pkg;

  localparam int N_OUT_DEFAULT = 32;
  localparam int SEL_W_DEFAULT = 5;

  // An out-of-range or unknown sel makes the compare false, so the result stays all-zero.
  function automatic logic [N_OUT_DEFAULT-1:0] onehot_decode(
    input logic [SEL_W_DEFAULT-1:0] sel,
    input logic                     in,
    input int                       n_out
  );
    logic [N_OUT_DEFAULT-1:0] result;
    result = '0;
    if ({1'b0, sel} < 6'(n_out)) begin
      result[sel] = in;
    end
    return result;
  endfunction

endpackage

// File: rtl/demux1_32_if.sv
// Steering bus for demux1_32: data bit, lane select and registered lane outputs.
// Carries the optional enable when DEMUX1_32_GATE_EN is defined.
interface demux1_32_if
  import demux1_32_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEFAULT
);
  localparam int SEL_W = $clog2(N_OUT);

  logic             in;
  logic [SEL_W-1:0] sel;
`ifdef DEMUX1_32_GATE_EN
  logic             en;
`endif
  logic [N_OUT-1:0] y;

`ifdef DEMUX1_32_GATE_EN
  modport master (output in, output sel, output en, input y);
  modport slave  (input in, input sel, input en, output y);
`else
  modport master (output in, output sel, input y);
  modport slave  (input in, input sel, output y);
`endif

endinterface

// File: rtl/demux1_32_decoder.sv
// Combinational lane decoder: maps in/sel to the N_OUT-bit next-state vector.
module demux_decoder
  import demux1_32_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEFAULT,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic             in,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] y_next
);

  logic [N_OUT_DEFAULT-1:0] full_decode;

  assign full_decode = onehot_decode(SEL_W_DEFAULT'(sel), in, N_OUT);

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
      assign y_next[gi] = full_decode[gi];
    end
  endgenerate

endmodule

// File: rtl/demux1_32.sv
// 1-to-32 demultiplexer with a registered output; y carries at most one set bit.
// Optional DEMUX1_32_GATE_EN adds an enable that holds y when low.
module demux1_32
  import demux1_32_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  demux1_32_if.slave  bus
);

  logic [N_OUT-1:0] y_next;
  logic [N_OUT-1:0] y_reg;

  demux_decoder #(
    .N_OUT (N_OUT)
  ) u_decoder (
    .in     (bus.in),
    .sel    (bus.sel),
    .y_next (y_next)
  );

  // Reset wins over the enable at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg <= '0;
    end else begin
`ifdef DEMUX1_32_GATE_EN
      if (bus.en) begin
        y_reg <= y_next;
      end
`else
      y_reg <= y_next;
`endif
    end
  end

  assign bus.y = y_reg;

endmodule

// File: tb/tb_demux1_32.sv
// Directed self-checking bench for demux1_32 (covers DEMUX1_32_GATE_EN when defined).
module tb_demux1_32;
  import demux1_32_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  demux1_32_if #(.N_OUT(32)) bus ();

  demux1_32 #(.N_OUT(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: y=%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] sweep_sel [20] = '{5'd3, 5'd17, 5'd31, 5'd0, 5'd8, 5'd22, 5'd1, 5'd14,
                                 5'd30, 5'd9, 5'd27, 5'd5, 5'd16, 5'd2, 5'd24, 5'd11,
                                 5'd29, 5'd6, 5'd19, 5'd13};
  logic [31:0] sweep_exp [20] = '{32'h0000_0008, 32'h0002_0000, 32'h8000_0000, 32'h0000_0001,
                                  32'h0000_0100, 32'h0040_0000, 32'h0000_0002, 32'h0000_4000,
                                  32'h4000_0000, 32'h0000_0200, 32'h0800_0000, 32'h0000_0020,
                                  32'h0001_0000, 32'h0000_0004, 32'h0100_0000, 32'h0000_0800,
                                  32'h2000_0000, 32'h0000_0040, 32'h0008_0000, 32'h0000_2000};

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b1;
    bus.in   = 1'b0;
    bus.sel  = '0;
`ifdef DEMUX1_32_GATE_EN
    bus.en   = 1'b1;
`endif
    @(negedge clk);

    // Reset with live data present
    rst_n   = 1'b0;
    bus.in  = 1'b1;
    bus.sel = 5'd7;
    tick();
    check("reset", bus.y, 32'h0000_0000);

    rst_n   = 1'b1;
    bus.sel = 5'd0;
    tick();
    check("route_sel0", bus.y, 32'h0000_0001);
    bus.sel = 5'd31;
    tick();
    check("route_sel31", bus.y, 32'h8000_0000);

    for (int i = 0; i < 20; i++) begin
      bus.sel = sweep_sel[i];
      tick();
      check($sformatf("sweep%0d_sel%0d", i, sweep_sel[i]), bus.y, sweep_exp[i]);
      check($sformatf("sweep%0d_popcount", i), 32'($countones(bus.y)), 32'd1);
    end

    bus.in  = 1'b0;
    bus.sel = 5'd19;
    tick();
    check("zero_data", bus.y, 32'h0000_0000);

    bus.in  = 1'b1;
    bus.sel = 5'd12;
    tick();
    check("mid_pre", bus.y, 32'h0000_1000);
    rst_n = 1'b0;
    tick();
    check("mid_reset", bus.y, 32'h0000_0000);
    rst_n = 1'b1;
    tick();
    check("mid_release", bus.y, 32'h0000_1000);

`ifdef DEMUX1_32_GATE_EN
    bus.sel = 5'd3;
    tick();
    check("gate_setup", bus.y, 32'h0000_0008);
    bus.en  = 1'b0;
    bus.sel = 5'd20;
    tick();
    check("gate_hold", bus.y, 32'h0000_0008);
    bus.en = 1'b1;
    tick();
    check("gate_resume", bus.y, 32'h0010_0000);
    bus.en = 1'b0;
    rst_n  = 1'b0;
    tick();
    check("gate_reset_dominates", bus.y, 32'h0000_0000);
    rst_n  = 1'b1;
    bus.en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
